fetch_stage: RTL and testbench

- Upstream companion of the instruction memory. Owns the program counter and drives the word-aligned fetch address.
- Captures the returned instruction word together with its PC into a small FIFO.
- Presents {instr, pc, pc+8} to decode through a valid/ready handshake.
- Handles backpressure without dropping or duplicating instructions.
- Handles branch redirects by flushing buffered instructions and reloading the PC.

---
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage.sv | 73 +++++++
 tb/tb_fetch_stage.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory address/data, redirect request and the
// decode-side valid/ready handshake with occupancy.
interface fetch_stage_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   imem_addr;
  logic [31:0]   imem_rd;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [31:0]   out_pcplus8;
  logic [CW-1:0] count;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, out_pcplus8, count,
    input  imem_rd, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, out_pcplus8, count,
    output imem_rd, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, buffers {instr, pc} pairs in a small FIFO
// and hands them to decode; a redirect flushes the FIFO and reloads the PC.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   instr_mem_r [DEPTH];
  logic [31:0]   pc_mem_r    [DEPTH];
  logic          pop_s;
  logic          push_s;

  // Handshake events; a full FIFO may still accept when the head leaves.
  always_comb begin
    pop_s  = (count_r != {CW{1'b0}}) & bus.out_ready;
    push_s = !bus.redirect & ((count_r < CW'(DEPTH)) | pop_s);
  end

  assign bus.imem_addr   = pc_r;
  assign bus.out_valid   = (count_r != {CW{1'b0}});
  assign bus.out_instr   = instr_mem_r[rd_ptr_r];
  assign bus.out_pc      = pc_mem_r[rd_ptr_r];
  assign bus.out_pcplus8 = pc_mem_r[rd_ptr_r] + 32'd8;
  assign bus.count       = count_r;

  // PC, pointers, occupancy and FIFO storage; redirect squashes any pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r     <= RESET_PC & 32'hFFFF_FFFC;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_r[i] <= 32'd0;
        pc_mem_r[i]    <= 32'd0;
      end
    end else if (bus.redirect) begin
      pc_r     <= bus.redirect_pc & 32'hFFFF_FFFC;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        instr_mem_r[wr_ptr_r] <= bus.imem_rd;
        pc_mem_r[wr_ptr_r]    <= pc_r;
        wr_ptr_r              <= wr_ptr_r + AW'(1);
        pc_r                  <= pc_r + 32'd4;
      end else begin
        pc_r <= pc_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queue-based reference model checked on
// every falling edge, plus literal expectations along the test plan.
module tb_fetch_stage;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_stage_if #(.DEPTH(DEPTH)) bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hE000_0000 + (a >> 2);
  endfunction

  assign bus.imem_rd = mem_word(bus.imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program counter plus an ordered queue of {instr, pc}.
  logic [31:0] m_pc = 32'h0000_0000;
  logic [63:0] m_q[$];

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_pc = 32'h0000_0000;
        m_q.delete();
      end else begin
        automatic bit pop = (m_q.size() != 0) && bus.out_ready;
        if (bus.redirect) begin
          m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
          m_q.delete();
        end else begin
          automatic bit push = (m_q.size() < DEPTH) || pop;
          if (pop) void'(m_q.pop_front());
          if (push) begin
            m_q.push_back({mem_word(m_pc), m_pc});
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("m_imem_addr", bus.imem_addr, m_pc);
      check("m_count", {30'd0, bus.count}, m_q.size());
      check("m_out_valid", {31'd0, bus.out_valid}, {31'd0, m_q.size() != 0});
      if (m_q.size() != 0) begin
        check("m_out_instr", bus.out_instr, m_q[0][63:32]);
        check("m_out_pc", bus.out_pc, m_q[0][31:0]);
        check("m_out_pcplus8", bus.out_pcplus8, m_q[0][31:0] + 32'd8);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.out_ready   = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    #1 reset = 1'b1;
    #1;
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_count", {30'd0, bus.count}, 32'd0);
    check("rst_instr", bus.out_instr, 32'd0);
    check("rst_pc", bus.out_pc, 32'd0);
    check("rst_pcplus8", bus.out_pcplus8, 32'd8);
    check("rst_addr", bus.imem_addr, 32'd0);
    step(); step();
    reset = 1'b0;

    // Free run.
    @(negedge clk);
    check("free_valid0", {31'd0, bus.out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("free_valid", {31'd0, bus.out_valid}, 32'd1);
      check("free_pc", bus.out_pc, 32'(4 * k));
      check("free_instr", bus.out_instr, 32'hE000_0000 + 32'(k));
      check("free_pcplus8", bus.out_pcplus8, 32'(4 * k + 8));
    end

    // Backpressure from reset.
    step();
    reset = 1'b1;
    bus.out_ready = 1'b0;
    step();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_count", {30'd0, bus.count}, 32'd2);
    check("bp_addr", bus.imem_addr, 32'd8);
    check("bp_pc", bus.out_pc, 32'd0);
    repeat (2) @(negedge clk);
    check("bp_count_hold", {30'd0, bus.count}, 32'd2);
    check("bp_addr_hold", bus.imem_addr, 32'd8);
    check("bp_pc_hold", bus.out_pc, 32'd0);
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("drain_pc0", bus.out_pc, 32'd0);
    @(negedge clk);
    check("fullpop_count", {30'd0, bus.count}, 32'd2);
    check("fullpop_addr", bus.imem_addr, 32'd12);
    check("drain_pc4", bus.out_pc, 32'd4);
    @(negedge clk);
    check("drain_pc8", bus.out_pc, 32'd8);
    @(negedge clk);
    check("drain_pc12", bus.out_pc, 32'd12);

    // Redirect while full.
    step();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0043;
    step();
    bus.redirect = 1'b0;
    @(negedge clk);
    check("redir_count", {30'd0, bus.count}, 32'd0);
    check("redir_valid", {31'd0, bus.out_valid}, 32'd0);
    check("redir_addr", bus.imem_addr, 32'h0000_0040);
    @(negedge clk);
    check("redir_valid1", {31'd0, bus.out_valid}, 32'd1);
    check("redir_pc", bus.out_pc, 32'h0000_0040);
    check("redir_instr", bus.out_instr, 32'hE000_0010);

    // Wrap-around.
    step();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    @(negedge clk);
    check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_pc0", bus.out_pc, 32'hFFFF_FFFC);
    check("wrap_pcplus8", bus.out_pcplus8, 32'h0000_0004);
    @(negedge clk);
    check("wrap_pc1", bus.out_pc, 32'h0000_0000);

    // Back-to-back redirects: last one wins.
    step();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    step();
    bus.redirect_pc = 32'h0000_0200;
    step();
    bus.redirect = 1'b0;
    @(negedge clk);
    check("b2b_addr", bus.imem_addr, 32'h0000_0200);

    // Reset dominates a simultaneous redirect.
    step();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0300;
    reset = 1'b1;
    step();
    @(negedge clk);
    check("rst_redir_addr", bus.imem_addr, 32'd0);
    step();
    reset = 1'b0;
    bus.redirect = 1'b0;

    // Random backpressure and occasional redirects, checked by the model.
    for (int i = 0; i < 300; i++) begin
      step();
      bus.out_ready   = 1'($urandom_range(0, 1));
      bus.redirect    = ($urandom_range(0, 15) == 0);
      bus.redirect_pc = $urandom;
    end
    step();
    bus.redirect = 1'b0;

    // Asynchronous reset while full, between edges.
    bus.out_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("async_pre_count", {30'd0, bus.count}, 32'd2);
    #2 reset = 1'b1;
    #1;
    check("async_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_count", {30'd0, bus.count}, 32'd0);
    check("async_addr", bus.imem_addr, 32'd0);
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("restart_pc", bus.out_pc, 32'd0);
    check("restart_instr", bus.out_instr, 32'hE000_0000);

    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
